// File: rtl/frame_feeder.sv
// Reads one frame from the input FIFO into the classifier core and decodes the one-hot result.
// Optional WAIT_RES watchdog is compiled in with FRAME_FEEDER_TIMEOUT_EN.
module frame_feeder #(
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_FRAME = 25,
  parameter int RES_W           = 10,
  parameter int TIMEOUT         = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_weight_done,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              core_input_valid,
  output logic              core_sof,
  output logic [DATA_W-1:0] core_d_in,
  input  logic              core_output_valid,
  input  logic [RES_W-1:0]  core_d_out,
  output logic              busy,
  output logic              result_valid,
  output logic [3:0]        result_digit,
  output logic              result_err
);

  localparam int CNT_W = $clog2(WORDS_PER_FRAME + 1);
  localparam logic [CNT_W-1:0] FRAME_LEN  = CNT_W'(WORDS_PER_FRAME);
  localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(WORDS_PER_FRAME - 1);

  if (TIMEOUT < 1 || WORDS_PER_FRAME < 1 || RES_W > 16) begin : g_param_check
    $error("frame_feeder: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_W   = 3'd1,
    STREAM   = 3'd2,
    WAIT_RES = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] issued_r;
  logic [CNT_W-1:0] emitted_r;
  logic             pend_r;
  logic             rd_en_s;

`ifdef FRAME_FEEDER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_r;
`endif

  // Returns {err, digit}: digit is the index of the single set bit, else 4'hF with err.
  function automatic logic [4:0] decode_onehot(input logic [RES_W-1:0] v);
    logic [4:0]  r;
    int unsigned ones;
    r    = {1'b1, 4'hF};
    ones = 32'd0;
    for (int k = 0; k < RES_W; k++) begin
      ones    = ones + {31'd0, v[k]};
      r[3:0]  = v[k] ? 4'(k) : r[3:0];
    end
    if (ones == 32'd1) begin
      r[4] = 1'b0;
    end else begin
      r = {1'b1, 4'hF};
    end
    return r;
  endfunction

  // FIFO read request: only while streaming, data available, weights loaded and frame not fully issued.
  always_comb begin
    rd_en_s = 1'b0;
    if (state_r == STREAM) begin
      rd_en_s = !fifo_empty && (issued_r < FRAME_LEN) && load_weight_done;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  assign fifo_rd_en = rd_en_s;

  // Frame sequencing, word capture and result decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r          <= IDLE;
      issued_r         <= '0;
      emitted_r        <= '0;
      pend_r           <= 1'b0;
      core_input_valid <= 1'b0;
      core_sof         <= 1'b0;
      core_d_in        <= '0;
      busy             <= 1'b0;
      result_valid     <= 1'b0;
      result_digit     <= 4'h0;
      result_err       <= 1'b0;
`ifdef FRAME_FEEDER_TIMEOUT_EN
      tmo_r            <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          core_input_valid <= 1'b0;
          core_sof         <= 1'b0;
          if (start) begin
            state_r <= WAIT_W;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        WAIT_W: begin
          if (load_weight_done) begin
            state_r   <= STREAM;
            issued_r  <= '0;
            emitted_r <= '0;
            pend_r    <= 1'b0;
          end else begin
            state_r   <= WAIT_W;
          end
        end
        STREAM: begin
          pend_r <= rd_en_s;
          if (rd_en_s) begin
            issued_r <= issued_r + CNT_W'(1);
          end else begin
            issued_r <= issued_r;
          end
          // fifo_data is valid the cycle after a read, so capture follows the pending flag.
          if (pend_r) begin
            core_input_valid <= 1'b1;
            core_d_in        <= fifo_data;
            core_sof         <= (emitted_r == '0);
            emitted_r        <= emitted_r + CNT_W'(1);
            if (emitted_r == LAST_WORD) begin
              state_r <= WAIT_RES;
`ifdef FRAME_FEEDER_TIMEOUT_EN
              tmo_r   <= '0;
`endif
            end else begin
              state_r <= STREAM;
            end
          end else begin
            core_input_valid <= 1'b0;
            core_sof         <= 1'b0;
          end
        end
        WAIT_RES: begin
          core_input_valid <= 1'b0;
          core_sof         <= 1'b0;
          if (core_output_valid) begin
            {result_err, result_digit} <= decode_onehot(core_d_out);
            result_valid <= 1'b1;
            state_r      <= DONE;
          end
`ifdef FRAME_FEEDER_TIMEOUT_EN
          else if (tmo_r == TMO_LAST) begin
            result_err   <= 1'b1;
            result_digit <= 4'hF;
            result_valid <= 1'b1;
            state_r      <= DONE;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
`else
          else begin
            state_r <= WAIT_RES;
          end
`endif
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r          <= IDLE;
          busy             <= 1'b0;
          core_input_valid <= 1'b0;
          core_sof         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/frame_feeder.md
Name: frame_feeder

Overview:
- Drives one image frame from the input FIFO's read side into the classifier core, then collects the core's 10-bit result and decodes it.
- Sits between the input FIFO (buf_out/buf_empty/rd_en) and the core (input_valid/sof/d_in, output_valid/d_out).
- Replaces the ad-hoc random read control with deterministic, frame-counted reads that are gated on weight-load completion.

Parameters:
- DATA_W, 32, FIFO and core input data width.
- WORDS_PER_FRAME, 25, number of DATA_W words per frame (25 x 32 covers a 784-pixel binary image).
- RES_W, 10, core result width, one bit per class.
- TIMEOUT, 4096, cycles allowed in WAIT_RES; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  single-cycle request to send one frame.
- load_weight_done  in  1  core weights loaded; level signal.
- fifo_empty  in  1  input FIFO buf_empty.
- fifo_data  in  DATA_W  input FIFO buf_out; valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  input FIFO read request.
- core_input_valid  out  1  word valid to the core.
- core_sof  out  1  first word of the frame.
- core_d_in  out  DATA_W  word to the core.
- core_output_valid  in  1  core result strobe.
- core_d_out  in  RES_W  core result, one-hot class.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  one-cycle pulse when the result is captured.
- result_digit  out  4  decoded class index 0-9; 4'hF on error.
- result_err  out  1  result was not one-hot, or timed out.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all counters 0.
  - fifo_rd_en, core_input_valid, core_sof, busy, result_valid, result_err = 0; result_digit=0; core_d_in=0.
  - Reset mid-frame abandons the frame. No partial words are emitted after reset releases.
- States:
  - IDLE: start=1 -> WAIT_W. start is ignored in all other states.
  - WAIT_W: load_weight_done=1 -> STREAM. If start and load_weight_done are both high in IDLE, go IDLE -> WAIT_W -> STREAM (one extra cycle).
  - STREAM:
    - fifo_rd_en = !fifo_empty && (issued < WORDS_PER_FRAME) && load_weight_done. This is combinational from registered state.
    - issued increments on each rd_en cycle.
    - One cycle after each rd_en, core_input_valid=1 and core_d_in <= fifo_data (registered capture). Latency from rd_en to core_input_valid is exactly 2 cycles.
    - core_sof=1 only with the first valid word of the frame.
    - Empty FIFO or a drop of load_weight_done stalls reads without losing position. Gaps between valid words are legal.
    - When the WORDS_PER_FRAME-th valid word is emitted -> WAIT_RES.
  - WAIT_RES: core_output_valid=1 -> capture core_d_out, decode, and go to DONE.
    - A core_output_valid seen during STREAM is ignored; it does not count as this frame's result.
  - DONE: pulse result_valid for one cycle, then go to IDLE. busy drops on the same edge that enters IDLE.
- Decode:
  - Exactly one bit k set: result_digit=k, result_err=0.
  - Zero bits or more than one bit set: result_digit=4'hF, result_err=1.
  - result_digit and result_err hold until the next capture.
- Counters:
  - issued and emitted are $clog2(WORDS_PER_FRAME+1) bits wide. They clear on entry to STREAM and never wrap within a frame.
- Never more than WORDS_PER_FRAME reads per frame, even when the FIFO holds more. Surplus words remain for the next frame.

Optional Feature:
- Macro: FRAME_FEEDER_TIMEOUT_EN.
- Defined:
  - WAIT_RES runs a cycle counter. Reaching TIMEOUT cycles without core_output_valid -> DONE with result_err=1 and result_digit=4'hF.
  - The counter clears on entry to WAIT_RES.
- Undefined:
  - No counter logic exists; WAIT_RES waits indefinitely. Only reset exits a hung frame.

Test Plan:
- FIFO preloaded with 25 words, load_weight_done=1, start pulse -> 25 consecutive core_input_valid cycles. sof is on word 0 only. Data order matches the FIFO order. fifo_rd_en is never asserted while fifo_empty=1.
- FIFO fill randomly stalled: fifo_empty toggles every 1-3 cycles -> still exactly 25 valid words, no duplicates or drops. busy stays high throughout.
- Core returns d_out=10'b0000001000 -> result_valid pulse, result_digit=3, result_err=0. Core returns 10'b0000000110 -> digit=4'hF, err=1.
- start with load_weight_done=0 for 50 cycles -> fifo_rd_en stays 0, then streaming begins 2 cycles after load_weight_done rises.
- rst asserted after word 10 -> all outputs 0 immediately. A new start after release sends a fresh 25-word frame with sof on its first word.
- FRAME_FEEDER_TIMEOUT_EN defined, TIMEOUT=16, no core_output_valid -> result_valid fires 16 cycles after entering WAIT_RES, with err=1 and digit=4'hF.
